stopwatch_lap_controller: RTL and testbench

//   Control FSM for the BCD stopwatch datapath (four cascaded mod-10 counters).

---
 rtl/stopwatch_lap_controller.sv | 187 ++++++++++++++++++
 tb/tb_stopwatch_lap_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_controller.sv
// Control FSM for a BCD stopwatch: counter run/clear, lap capture and display select.
// Lap buffer holds up to LAP_DEPTH times; RECALL lets the user browse them while stopped.
module stopwatch_lap_controller #(
    parameter int LAP_DEPTH  = 4,
    parameter int IDX_W      = 2,
    parameter int HOLD_TICKS = 300,
    parameter int TIME_W     = 16
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              tick_100hz,
    input  logic              start_stop_p,
    input  logic              lap_p,
    input  logic              recall_p,
    input  logic              clear_p,
    input  logic [TIME_W-1:0] live_time,
    output logic              run,
    output logic              clear_counters,
    output logic [TIME_W-1:0] display_time,
    output logic              display_is_lap,
    output logic [IDX_W-1:0]  lap_index,
    output logic [IDX_W:0]    lap_count,
    output logic              lap_full
);

    typedef enum logic [2:0] {
        IDLE,
        RUNNING,
        STOPPED,
        LAP_HOLD,
        RECALL
    } state_t;

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(LAP_DEPTH);

    state_t state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TIME_W-1:0] laps [LAP_DEPTH];

    logic              run_d;
    logic              clr_d;
    logic [TIME_W-1:0] disp_d;
    logic              is_lap_d;
    logic [IDX_W-1:0]  idx_d;
    logic [IDX_W:0]    cnt_d;
    logic              full_d;
    logic              wr_en;
    logic              cap_ok;

    assign cap_ok = (lap_count < DEPTH);

    // State register and registered outputs; reset zeroes everything.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state_q        <= IDLE;
            hold_q         <= '0;
            run            <= 1'b0;
            clear_counters <= 1'b0;
            display_time   <= '0;
            display_is_lap <= 1'b0;
            lap_index      <= '0;
            lap_count      <= '0;
            lap_full       <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            run            <= run_d;
            clear_counters <= clr_d;
            display_time   <= disp_d;
            display_is_lap <= is_lap_d;
            lap_index      <= idx_d;
            lap_count      <= cnt_d;
            lap_full       <= full_d;
        end
    end

    // Lap storage; contents are don't-care after reset so it has none.
    always_ff @(posedge CLK_50M) begin
        if (!reset && wr_en) begin
            laps[lap_count[IDX_W-1:0]] <= live_time;
        end
    end

    // Next state and next output values; clear_p outranks every other pulse.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clr_d   = 1'b0;
        idx_d   = lap_index;
        cnt_d   = lap_count;
        full_d  = lap_full;
        wr_en   = 1'b0;

        if (clear_p) begin
            state_d = IDLE;
            clr_d   = 1'b1;
            idx_d   = '0;
            cnt_d   = '0;
            full_d  = 1'b0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_stop_p) state_d = RUNNING;
                end
                RUNNING: begin
                    if (start_stop_p) begin
                        state_d = STOPPED;
                    end else if (lap_p) begin
                        if (cap_ok) begin
                            wr_en   = 1'b1;
                            cnt_d   = lap_count + 1'b1;
                            hold_d  = '0;
                            state_d = LAP_HOLD;
                        end else begin
                            full_d = 1'b1;
                        end
                    end
                end
                LAP_HOLD: begin
                    if (start_stop_p) begin
                        state_d = STOPPED;
                        hold_d  = '0;
                    end else if (lap_p && cap_ok) begin
                        wr_en  = 1'b1;
                        cnt_d  = lap_count + 1'b1;
                        hold_d = '0;
                    end else begin
                        if (lap_p) full_d = 1'b1;
                        if (tick_100hz) begin
                            if (hold_q == HOLD_LAST) begin
                                hold_d  = '0;
                                state_d = RUNNING;
                            end else begin
                                hold_d = hold_q + 1'b1;
                            end
                        end
                    end
                end
                STOPPED: begin
                    if (start_stop_p) begin
                        state_d = RUNNING;
                    end else if (recall_p && lap_count != '0) begin
                        state_d = RECALL;
                        idx_d   = '0;
                    end
                end
                RECALL: begin
                    if (start_stop_p) begin
                        state_d = RUNNING;
                    end else if (lap_p) begin
                        state_d = STOPPED;
                    end else if (recall_p) begin
                        if ({1'b0, lap_index} == lap_count - 1'b1)
                            idx_d = '0;
                        else
                            idx_d = lap_index + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Display source follows the state being entered.
    always_comb begin
        disp_d   = live_time;
        is_lap_d = 1'b0;
        run_d    = 1'b0;
        unique case (state_d)
            LAP_HOLD: begin
                disp_d   = wr_en ? live_time : display_time;
                is_lap_d = 1'b1;
                run_d    = 1'b1;
            end
            RECALL: begin
                disp_d   = laps[idx_d];
                is_lap_d = 1'b1;
            end
            RUNNING: run_d = 1'b1;
            default: disp_d = live_time;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// Testbench for stopwatch_lap_controller: table vectors plus hand-written
// sequences, expected records queued at drive time and checked after each edge.
module tb_stopwatch_lap_controller;

    typedef struct packed {
        logic        run;
        logic        clr;
        logic [15:0] disp;
        logic        is_lap;
        logic [1:0]  idx;
        logic [2:0]  cnt;
        logic        full;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } sb_t;

    typedef struct {
        string       nm;
        logic        r, ss, lp, rc, cl, tk;
        logic [15:0] lv;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, tick, ss_p, lap_p, rec_p, clr_p;
    logic [15:0] live;
    logic        run, clear_counters, display_is_lap, lap_full;
    logic [15:0] display_time;
    logic [1:0]  lap_index;
    logic [2:0]  lap_count;

    int checks = 0;
    int errors = 0;
    sb_t sbq[$];
    vec_t vt[$];

    stopwatch_lap_controller dut (
        .CLK_50M       (clk),
        .reset         (reset),
        .tick_100hz    (tick),
        .start_stop_p  (ss_p),
        .lap_p         (lap_p),
        .recall_p      (rec_p),
        .clear_p       (clr_p),
        .live_time     (live),
        .run           (run),
        .clear_counters(clear_counters),
        .display_time  (display_time),
        .display_is_lap(display_is_lap),
        .lap_index     (lap_index),
        .lap_count     (lap_count),
        .lap_full      (lap_full)
    );

    always #10 clk = ~clk;

    function automatic exp_t mk(input logic rn, input logic cl,
                                input logic [15:0] d, input logic il,
                                input logic [1:0] ix, input logic [2:0] c,
                                input logic f);
        exp_t e;
        e.run = rn; e.clr = cl; e.disp = d; e.is_lap = il;
        e.idx = ix; e.cnt = c; e.full = f;
        return e;
    endfunction

    function automatic logic [15:0] bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic void add(input string nm, input logic r, input logic ss,
                                input logic lp, input logic rc, input logic cl,
                                input logic tk, input logic [15:0] lv,
                                input exp_t e);
        vec_t v;
        v.nm = nm; v.r = r; v.ss = ss; v.lp = lp; v.rc = rc;
        v.cl = cl; v.tk = tk; v.lv = lv; v.e = e;
        vt.push_back(v);
    endfunction

    task automatic step(input string nm, input logic r, input logic ss,
                        input logic lp, input logic rc, input logic cl,
                        input logic tk, input logic [15:0] lv, input exp_t e);
        sb_t s;
        @(negedge clk);
        reset = r; ss_p = ss; lap_p = lp; rec_p = rc;
        clr_p = cl; tick = tk; live = lv;
        s.nm = nm; s.e = e;
        sbq.push_back(s);
        @(posedge clk);
    endtask

    // Scoreboard: each edge retires the oldest expected record.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            sb_t s;
            exp_t a;
            s = sbq.pop_front();
            a = mk(run, clear_counters, display_time, display_is_lap,
                   lap_index, lap_count, lap_full);
            checks++;
            if (a !== s.e) begin
                errors++;
                $display("FAIL %s: got run=%b clr=%b disp=%h lap=%b idx=%0d cnt=%0d full=%b want run=%b clr=%b disp=%h lap=%b idx=%0d cnt=%0d full=%b",
                         s.nm, a.run, a.clr, a.disp, a.is_lap, a.idx, a.cnt, a.full,
                         s.e.run, s.e.clr, s.e.disp, s.e.is_lap, s.e.idx, s.e.cnt, s.e.full);
            end
        end
    end

    initial begin
        reset = 1'b1; ss_p = 0; lap_p = 0; rec_p = 0; clr_p = 0; tick = 0;
        live = '0;

        add("t5_start",    0, 1, 0, 0, 0, 0, 16'h0400, mk(1, 0, 16'h0400, 0, 0, 4, 1));
        add("t5_clr_ss",   0, 1, 0, 0, 1, 0, 16'h0401, mk(0, 1, 16'h0401, 0, 0, 0, 0));
        add("t5_after",    0, 0, 0, 0, 0, 0, 16'h0000, mk(0, 0, 16'h0000, 0, 0, 0, 0));
        add("t5_idle_lap", 0, 0, 1, 0, 0, 0, 16'h0000, mk(0, 0, 16'h0000, 0, 0, 0, 0));
        add("t5_idle_rec", 0, 0, 0, 1, 0, 0, 16'h0000, mk(0, 0, 16'h0000, 0, 0, 0, 0));
        add("t4_start",    0, 1, 0, 0, 0, 0, 16'h0000, mk(1, 0, 16'h0000, 0, 0, 0, 0));
        add("t4_lap0",     0, 0, 1, 0, 0, 0, 16'h0100, mk(1, 0, 16'h0100, 1, 0, 1, 0));
        add("t4_lap1",     0, 0, 1, 0, 0, 0, 16'h0200, mk(1, 0, 16'h0200, 1, 0, 2, 0));
        add("t4_lap2",     0, 0, 1, 0, 0, 0, 16'h0300, mk(1, 0, 16'h0300, 1, 0, 3, 0));
        add("t4_stop_pri", 0, 1, 1, 0, 0, 0, 16'h0310, mk(0, 0, 16'h0310, 0, 0, 3, 0));
        add("t4_rec0",     0, 0, 0, 1, 0, 0, 16'h0310, mk(0, 0, 16'h0100, 1, 0, 3, 0));
        add("t4_rec1",     0, 0, 0, 1, 0, 0, 16'h0310, mk(0, 0, 16'h0200, 1, 1, 3, 0));
        add("t4_rec2",     0, 0, 0, 1, 0, 0, 16'h0310, mk(0, 0, 16'h0300, 1, 2, 3, 0));
        add("t4_rec_wrap", 0, 0, 0, 1, 0, 0, 16'h0310, mk(0, 0, 16'h0100, 1, 0, 3, 0));
        add("t4_resume",   0, 1, 0, 0, 0, 0, 16'h0311, mk(1, 0, 16'h0311, 0, 0, 3, 0));
        add("t4_run_pri",  0, 1, 1, 0, 0, 0, 16'h0312, mk(0, 0, 16'h0312, 0, 0, 3, 0));

        step("reset", 1, 0, 0, 0, 0, 0, 16'h0999, mk(0, 0, 16'h0000, 0, 0, 0, 0));
        step("idle",  0, 0, 0, 0, 0, 0, 16'h0000, mk(0, 0, 16'h0000, 0, 0, 0, 0));

        step("t1_start", 0, 1, 0, 0, 0, 0, 16'h0000, mk(1, 0, 16'h0000, 0, 0, 0, 0));
        for (int i = 1; i <= 250; i++)
            step("t1_run", 0, 0, 0, 0, 0, 1, bcd(i), mk(1, 0, bcd(i), 0, 0, 0, 0));
        step("t1_stop",    0, 1, 0, 0, 0, 0, 16'h0250, mk(0, 0, 16'h0250, 0, 0, 0, 0));
        step("t1_lap_ign", 0, 0, 1, 0, 0, 0, 16'h0250, mk(0, 0, 16'h0250, 0, 0, 0, 0));
        step("t1_rec_ign", 0, 0, 0, 1, 0, 0, 16'h0250, mk(0, 0, 16'h0250, 0, 0, 0, 0));

        step("t2_clear", 0, 0, 0, 0, 1, 0, 16'h0250, mk(0, 1, 16'h0250, 0, 0, 0, 0));
        step("t2_start", 0, 1, 0, 0, 0, 0, 16'h0000, mk(1, 0, 16'h0000, 0, 0, 0, 0));
        step("t2_lap",   0, 0, 1, 0, 0, 0, 16'h0123, mk(1, 0, 16'h0123, 1, 0, 1, 0));
        for (int k = 1; k <= 299; k++)
            step("t2_hold", 0, 0, 0, 0, 0, 1, bcd(123 + k), mk(1, 0, 16'h0123, 1, 0, 1, 0));
        step("t2_release", 0, 0, 0, 0, 0, 1, 16'h0423, mk(1, 0, 16'h0423, 0, 0, 1, 0));
        step("t2_running", 0, 0, 0, 0, 0, 0, 16'h0424, mk(1, 0, 16'h0424, 0, 0, 1, 0));

        step("t3_clear", 0, 0, 0, 0, 1, 0, 16'h0000, mk(0, 1, 16'h0000, 0, 0, 0, 0));
        step("t3_start", 0, 1, 0, 0, 0, 0, 16'h0000, mk(1, 0, 16'h0000, 0, 0, 0, 0));
        for (int j = 0; j < 4; j++)
            step("t3_lap", 0, 0, 1, 0, 0, 0, 16'(16'h0301 + j),
                 mk(1, 0, 16'(16'h0301 + j), 1, 0, 3'(j + 1), 0));
        step("t3_lap5", 0, 0, 1, 0, 0, 0, 16'h0305, mk(1, 0, 16'h0304, 1, 0, 4, 1));
        step("t3_stop", 0, 1, 0, 0, 0, 0, 16'h0306, mk(0, 0, 16'h0306, 0, 0, 4, 1));
        for (int j = 0; j < 4; j++)
            step("t3_recall", 0, 0, 0, 1, 0, 0, 16'h0306,
                 mk(0, 0, 16'(16'h0301 + j), 1, 2'(j), 4, 1));
        step("t3_wrap", 0, 0, 0, 1, 0, 0, 16'h0306, mk(0, 0, 16'h0301, 1, 0, 4, 1));
        step("t3_exit", 0, 0, 1, 0, 0, 0, 16'h0306, mk(0, 0, 16'h0306, 0, 0, 4, 1));

        for (int v = 0; v < vt.size(); v++)
            step(vt[v].nm, vt[v].r, vt[v].ss, vt[v].lp, vt[v].rc,
                 vt[v].cl, vt[v].tk, vt[v].lv, vt[v].e);

        step("t6_clear", 0, 0, 0, 0, 1, 0, 16'h0000, mk(0, 1, 16'h0000, 0, 0, 0, 0));
        step("t6_start", 0, 1, 0, 0, 0, 0, 16'h0000, mk(1, 0, 16'h0000, 0, 0, 0, 0));
        step("t6_lap",   0, 0, 1, 0, 0, 0, 16'h0777, mk(1, 0, 16'h0777, 1, 0, 1, 0));
        step("t6_reset", 1, 0, 0, 0, 0, 1, 16'h0778, mk(0, 0, 16'h0000, 0, 0, 0, 0));
        step("t6_idle",  0, 0, 0, 0, 0, 0, 16'h0779, mk(0, 0, 16'h0779, 0, 0, 0, 0));
        step("t6_start2", 0, 1, 0, 0, 0, 0, 16'h0780, mk(1, 0, 16'h0780, 0, 0, 0, 0));

        @(negedge clk);
        ss_p = 0; lap_p = 0; rec_p = 0; clr_p = 0; tick = 0;
        @(negedge clk);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
